// File: rtl/acra_pkg.sv
// Shared types and helpers for the ACRA adder arbiter.
// Optional feature macro: ACRA_FORCE_EXACT_EN (adds force_exact input).
package acra_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_HOLD,
    ST_RESP
  } acra_state_e;

  function automatic int acra_segs(input int w);
    return w / 2;
  endfunction

  function automatic int acra_lw(input int w);
    return $clog2(w / 2 + 1);
  endfunction

  // Level L marks the L low-order segments approximate, clamped to segs.
  function automatic logic [31:0] acra_therm(
    input int unsigned lvl,
    input int unsigned segs
  );
    int unsigned l;
    l = (lvl > segs) ? segs : lvl;
    acra_therm = '0;
    for (int unsigned k = 0; k < 32; k++)
      if (k < l) acra_therm[k] = 1'b1;
  endfunction

endpackage

// File: rtl/acra_rr_arbiter.sv
// Rotating-priority one-hot grant; search starts just after i_last.
// Purely combinational.
module acra_rr_arbiter #(
  parameter int NREQ = 4,
  parameter int IW   = 2
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_last,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW-1:0] w_idx;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_idx = '0;
    for (int i = 1; i <= NREQ; i++) begin
      w_idx = IW'((int'(i_last) + i) % NREQ);
      if (!o_any && i_req[w_idx]) begin
        o_gnt[w_idx] = 1'b1;
        o_idx        = w_idx;
        o_any        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/acra_adder_arbiter.sv
// Shares one ACRA adder between NREQ requesters, round-robin.
// Optional feature macro: ACRA_FORCE_EXACT_EN (force_exact input).
module acra_adder_arbiter
  import acra_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int SEGS      = acra_segs(WIDTH),
  parameter int ADDER_LAT = 1,
  parameter int LW        = acra_lw(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  input  logic [NREQ-1:0]         req_cin,
  input  logic [NREQ*LW-1:0]      req_lvl,
`ifdef ACRA_FORCE_EXACT_EN
  input  logic                    force_exact,
`endif
  output logic [WIDTH-1:0]        add_a,
  output logic [WIDTH-1:0]        add_b,
  output logic                    add_cin,
  output logic [SEGS-1:0]         add_sapp,
  input  logic [WIDTH-1:0]        add_sum,
  input  logic                    add_cout,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [$clog2(NREQ)-1:0] rsp_id,
  output logic [WIDTH-1:0]        rsp_sum,
  output logic                    rsp_cout,
  output logic                    rsp_approx
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(ADDER_LAT + 1);

  acra_state_e      r_state;
  logic [IW-1:0]    r_last;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_cin;
  logic [SEGS-1:0]  r_sapp;
  logic             r_rsp_valid;
  logic [IW-1:0]    r_rsp_id;
  logic [WIDTH-1:0] r_rsp_sum;
  logic             r_rsp_cout;
  logic             r_rsp_approx;

  logic [NREQ-1:0]  w_gnt;
  logic [IW-1:0]    w_gidx;
  logic             w_any;
  logic [LW-1:0]    w_lvl;
  logic [SEGS-1:0]  w_sapp;

  acra_rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .i_req  (req_valid),
    .i_last (r_last),
    .o_gnt  (w_gnt),
    .o_idx  (w_gidx),
    .o_any  (w_any)
  );

`ifdef ACRA_FORCE_EXACT_EN
  assign w_lvl = force_exact ? '0 : req_lvl[w_gidx*LW +: LW];
`else
  assign w_lvl = req_lvl[w_gidx*LW +: LW];
`endif

  assign w_sapp    = SEGS'(acra_therm(32'(w_lvl), SEGS));
  assign req_ready = (r_state == ST_IDLE) ? w_gnt : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_last       <= IW'(NREQ - 1);
      r_cnt        <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_cin        <= 1'b0;
      r_sapp       <= '0;
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= '0;
      r_rsp_sum    <= '0;
      r_rsp_cout   <= 1'b0;
      r_rsp_approx <= 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a     <= req_a[w_gidx*WIDTH +: WIDTH];
            r_b     <= req_b[w_gidx*WIDTH +: WIDTH];
            r_cin   <= req_cin[w_gidx];
            r_sapp  <= w_sapp;
            r_last  <= w_gidx;
            r_cnt   <= CW'(ADDER_LAT - 1);
            r_state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (r_cnt == '0) begin
            r_rsp_sum    <= add_sum;
            r_rsp_cout   <= add_cout;
            r_rsp_approx <= |r_sapp;
            r_rsp_id     <= r_last;
            r_rsp_valid  <= 1'b1;
            r_state      <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign add_a      = r_a;
  assign add_b      = r_b;
  assign add_cin    = r_cin;
  assign add_sapp   = r_sapp;
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_sum    = r_rsp_sum;
  assign rsp_cout   = r_rsp_cout;
  assign rsp_approx = r_rsp_approx;

endmodule

// File: tb/tb_acra_adder_arbiter.sv
// Directed bench for acra_adder_arbiter (ADDER_LAT=1 and ADDER_LAT=3).
// Honours ACRA_FORCE_EXACT_EN when defined.
module tb_acra_adder_arbiter;

  localparam int NREQ = 4;
  localparam int W    = 8;
  localparam int SEGS = 4;
  localparam int LW   = 3;
  localparam int IW   = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NREQ-1:0]   req_valid, req_ready, req_cin;
  logic [NREQ*W-1:0] req_a, req_b;
  logic [NREQ*LW-1:0] req_lvl;
  logic [W-1:0]      add_a, add_b, add_sum, rsp_sum;
  logic              add_cin, add_cout;
  logic [SEGS-1:0]   add_sapp;
  logic              rsp_valid, rsp_ready, rsp_cout, rsp_approx;
  logic [IW-1:0]     rsp_id;
  logic              force_exact;

  logic [NREQ-1:0]   s_req_valid, s_req_ready, s_req_cin;
  logic [NREQ*W-1:0] s_req_a, s_req_b;
  logic [NREQ*LW-1:0] s_req_lvl;
  logic [W-1:0]      s_add_a, s_add_b, s_add_sum, s_rsp_sum;
  logic              s_add_cin, s_add_cout;
  logic [SEGS-1:0]   s_add_sapp;
  logic              s_rsp_valid, s_rsp_ready, s_rsp_cout, s_rsp_approx;
  logic [IW-1:0]     s_rsp_id;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  // Exact reference adder standing in for the shared ACRA hardware
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'b0, add_cin};
  assign {s_add_cout, s_add_sum} =
    {1'b0, s_add_a} + {1'b0, s_add_b} + {8'b0, s_add_cin};

  acra_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .ADDER_LAT(1)) u_dut (
    .clk (clk), .rst (rst),
    .req_valid (req_valid), .req_ready (req_ready),
    .req_a (req_a), .req_b (req_b), .req_cin (req_cin), .req_lvl (req_lvl),
`ifdef ACRA_FORCE_EXACT_EN
    .force_exact (force_exact),
`endif
    .add_a (add_a), .add_b (add_b), .add_cin (add_cin),
    .add_sapp (add_sapp), .add_sum (add_sum), .add_cout (add_cout),
    .rsp_valid (rsp_valid), .rsp_ready (rsp_ready), .rsp_id (rsp_id),
    .rsp_sum (rsp_sum), .rsp_cout (rsp_cout), .rsp_approx (rsp_approx)
  );

  acra_adder_arbiter #(.NREQ(NREQ), .WIDTH(W), .ADDER_LAT(3)) u_dut3 (
    .clk (clk), .rst (rst),
    .req_valid (s_req_valid), .req_ready (s_req_ready),
    .req_a (s_req_a), .req_b (s_req_b), .req_cin (s_req_cin),
    .req_lvl (s_req_lvl),
`ifdef ACRA_FORCE_EXACT_EN
    .force_exact (1'b0),
`endif
    .add_a (s_add_a), .add_b (s_add_b), .add_cin (s_add_cin),
    .add_sapp (s_add_sapp), .add_sum (s_add_sum), .add_cout (s_add_cout),
    .rsp_valid (s_rsp_valid), .rsp_ready (s_rsp_ready), .rsp_id (s_rsp_id),
    .rsp_sum (s_rsp_sum), .rsp_cout (s_rsp_cout),
    .rsp_approx (s_rsp_approx)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic cin,
                         input logic [LW-1:0] lvl);
    req_a[i*W +: W]     = a;
    req_b[i*W +: W]     = b;
    req_cin[i]          = cin;
    req_lvl[i*LW +: LW] = lvl;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #2;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0; req_a = '0; req_b = '0; req_cin = '0; req_lvl = '0;
    rsp_ready = 1'b1; force_exact = 1'b0;
    s_req_valid = '0; s_req_a = '0; s_req_b = '0; s_req_cin = '0;
    s_req_lvl = '0; s_rsp_ready = 1'b1;
    rst = 1'b1;
    tick(); tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      bad++;
      $display("FAIL reset_hs: rsp_valid=%b req_ready=%b want 0/0000",
               rsp_valid, req_ready);
    end
    total++;
    if ({add_a, add_b, add_cin, add_sapp} !== 21'b0 ||
        {rsp_id, rsp_sum, rsp_cout, rsp_approx} !== 12'b0) begin
      bad++;
      $display("FAIL reset_out: add=%h/%h/%b/%b rsp=%0d/%h/%b/%b want 0",
               add_a, add_b, add_cin, add_sapp,
               rsp_id, rsp_sum, rsp_cout, rsp_approx);
    end
    @(negedge clk);
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    set_req(0, 8'h3C, 8'h0F, 1'b0, 3'd0);
    req_valid = 4'b0001;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL basic_ready: got %b want 0001", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (add_a !== 8'h3C || add_b !== 8'h0F || add_sapp !== 4'b0000 ||
        rsp_valid !== 1'b0 || req_ready !== 4'b0) begin
      bad++;
      $display("FAIL basic_hold: a=%h b=%h sapp=%b v=%b rdy=%b want 3c 0f 0000 0 0000",
               add_a, add_b, add_sapp, rsp_valid, req_ready);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_sum !== 8'h4B ||
        rsp_cout !== 1'b0 || rsp_approx !== 1'b0) begin
      bad++;
      $display("FAIL basic_rsp: v=%b id=%0d sum=%h c=%b ap=%b want 1 0 4b 0 0",
               rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_approx);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL basic_idle: rsp_valid=%b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    int k;
    int e;
    logic [W-1:0] exp_sum;
    do_reset();
    for (int i = 0; i < NREQ; i++)
      set_req(i, 8'(i * 16 + 1), 8'(i), 1'b0, 3'd0);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    #1;
    for (int n = 0; n < 5; n++) begin
      e = n % NREQ;
      exp_sum = 8'(e * 17 + 1);
      k = 0;
      while (req_ready === 4'b0 && k < 8) begin tick(); k++; end
      total++;
      if (req_ready !== 4'(1 << e)) begin
        bad++;
        $display("FAIL rr_grant%0d: got %b want %b", n, req_ready, 4'(1 << e));
      end
      tick();
      k = 0;
      while (rsp_valid !== 1'b1 && k < 8) begin tick(); k++; end
      total++;
      if (rsp_valid !== 1'b1 || rsp_id !== 2'(e) || rsp_sum !== exp_sum) begin
        bad++;
        $display("FAIL rr_rsp%0d: v=%b id=%0d sum=%h want 1 %0d %h",
                 n, rsp_valid, rsp_id, rsp_sum, e, exp_sum);
      end
      tick();
    end
    req_valid = '0;
    tick();
  endtask

  task automatic test_approx();
    set_req(2, 8'h05, 8'h06, 1'b0, 3'd2);
    req_valid = 4'b0100;
    #1;
    total++;
    if (req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL apx_ready: got %b want 0100", req_ready);
    end
    tick();
    req_valid = '0;
    total++;
    if (add_sapp !== 4'b0011) begin
      bad++;
      $display("FAIL apx_sapp2: got %b want 0011", add_sapp);
    end
    tick();
    total++;
    if (rsp_valid !== 1'b1 || rsp_approx !== 1'b1 || rsp_id !== 2'd2) begin
      bad++;
      $display("FAIL apx_rsp2: v=%b ap=%b id=%0d want 1 1 2",
               rsp_valid, rsp_approx, rsp_id);
    end
    tick();
    set_req(2, 8'h05, 8'h06, 1'b0, 3'd7);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    total++;
    if (add_sapp !== 4'b1111) begin
      bad++;
      $display("FAIL apx_clamp: got %b want 1111", add_sapp);
    end
    tick();
    total++;
    if (rsp_approx !== 1'b1 || rsp_sum !== 8'h0B) begin
      bad++;
      $display("FAIL apx_rsp7: ap=%b sum=%h want 1 0b", rsp_approx, rsp_sum);
    end
    tick();
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    set_req(1, 8'h10, 8'h20, 1'b0, 3'd0);
    req_valid = 4'b0010;
    tick();
    req_valid = 4'b1111;
    tick();
    for (int c = 0; c < 5; c++) begin
      total++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 8'h30 || rsp_id !== 2'd1 ||
          req_ready !== 4'b0) begin
        bad++;
        $display("FAIL bp_hold%0d: v=%b sum=%h id=%0d rdy=%b want 1 30 1 0000",
                 c, rsp_valid, rsp_sum, rsp_id, req_ready);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    total++;
    if (rsp_valid !== 1'b0 || req_ready !== 4'b0100) begin
      bad++;
      $display("FAIL bp_release: v=%b rdy=%b want 0 0100", rsp_valid, req_ready);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(0, 8'h01, 8'h02, 1'b0, 3'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    #2;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      total++;
      if (rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL rstmid_v%0d: rsp_valid=%b want 0", c, rsp_valid);
      end
    end
    req_valid = 4'b1111;
    #1;
    total++;
    if (req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_grant: got %b want 0001", req_ready);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
  endtask

  task automatic test_lat3();
    s_req_a[7:0] = 8'hFF;
    s_req_b[7:0] = 8'h01;
    s_req_cin[0] = 1'b1;
    s_req_lvl[2:0] = 3'd0;
    s_req_valid = 4'b0001;
    #1;
    total++;
    if (s_req_ready !== 4'b0001) begin
      bad++;
      $display("FAIL lat3_ready: got %b want 0001", s_req_ready);
    end
    tick();
    s_req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (s_add_a !== 8'hFF || s_add_b !== 8'h01 || s_add_cin !== 1'b1 ||
          s_rsp_valid !== 1'b0) begin
        bad++;
        $display("FAIL lat3_hold%0d: a=%h b=%h c=%b v=%b want ff 01 1 0",
                 c, s_add_a, s_add_b, s_add_cin, s_rsp_valid);
      end
      tick();
    end
    total++;
    if (s_rsp_valid !== 1'b1 || s_rsp_sum !== 8'h01 || s_rsp_cout !== 1'b1) begin
      bad++;
      $display("FAIL lat3_rsp: v=%b sum=%h c=%b want 1 01 1",
               s_rsp_valid, s_rsp_sum, s_rsp_cout);
    end
    tick();
  endtask

  task automatic test_force_exact();
`ifdef ACRA_FORCE_EXACT_EN
    set_req(3, 8'h11, 8'h22, 1'b0, 3'd4);
    force_exact = 1'b1;
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    force_exact = 1'b0;
    total++;
    if (add_sapp !== 4'b0000) begin
      bad++;
      $display("FAIL force_sapp: got %b want 0000", add_sapp);
    end
    tick();
    total++;
    if (rsp_approx !== 1'b0 || rsp_sum !== 8'h33) begin
      bad++;
      $display("FAIL force_rsp: ap=%b sum=%h want 0 33", rsp_approx, rsp_sum);
    end
    tick();
`else
    set_req(3, 8'h11, 8'h22, 1'b0, 3'd4);
    req_valid = 4'b1000;
    tick();
    req_valid = '0;
    total++;
    if (add_sapp !== 4'b1111) begin
      bad++;
      $display("FAIL lvl4_sapp: got %b want 1111", add_sapp);
    end
    tick();
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_approx();
    test_backpressure();
    test_reset_mid();
    test_lat3();
    test_force_exact();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
